neuron_layer_ctrl: RTL
======================

Name: neuron_layer_ctrl

Overview:
Sequencer that runs one fully-connected layer through a single `neuron` MAC instance. It fetches inputs, weights and biases from three synchronous-read memories and drives the neuron's en/mac/n_in/wgh/bias. It captures each n_out result and writes it to an output buffer, then signals done. It sits between the layer memories and the neuron, and is started by the top-level network scheduler.

Parameters:
MAX_IN, 8, maximum inputs per neuron; also the weight row stride
MAX_NEU, 8, maximum neurons per layer
DATA_W, 16, data width (Q8.8 signed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  launch layer; sampled in IDLE only
abort  in  1  cancel the running layer
cfg_n_in  in  clog2(MAX_IN)+1  inputs per neuron; latched at start
cfg_n_neu  in  clog2(MAX_NEU)+1  neurons in the layer; latched at start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the layer completes
in_addr  out  clog2(MAX_IN)  input memory read address
in_rdata  in  DATA_W  input memory data, valid 1 cycle after address
w_addr  out  clog2(MAX_IN*MAX_NEU)  weight address = j*MAX_IN+i
w_rdata  in  DATA_W  weight data, 1-cycle latency
b_addr  out  clog2(MAX_NEU)  bias address = j
b_rdata  in  DATA_W  bias data, 1-cycle latency
neu_clr  out  1  neuron reset/clear pulse
neu_en  out  1  neuron enable
neu_mac  out  1  neuron bias/finalise select
neu_n_in  out  DATA_W  = in_rdata (combinational pass-through)
neu_wgh  out  DATA_W  = w_rdata (pass-through)
neu_bias  out  DATA_W  = b_rdata (pass-through)
neu_out  in  DATA_W  neuron result, valid the cycle after the neu_mac edge
out_we  out  1  output buffer write strobe
out_addr  out  clog2(MAX_NEU)  output index j
out_data  out  DATA_W  = neu_out while out_we

Behaviour:
- Reset: state=IDLE, i=j=0. busy, done, neu_clr, neu_en, neu_mac, out_we = 0. All addresses 0.
- Neuron contract:
  - en=1, mac=0 accumulates n_in*wgh on each edge.
  - en=1, mac=1 adds bias, registers n_out and clears the accumulator.
- Latch rules at start: cfg_n_in and cfg_n_neu are clamped to MAX_IN/MAX_NEU and latched. They are ignored while busy.
- States:
  - IDLE: start & !abort -> CLR. start while busy has no effect.
  - CLR (1 cycle): neu_clr=1; i=0, j=0. If either latched count is 0 -> DONE, otherwise -> ACC.
  - ACC (n_in cycles): issue in_addr=i and w_addr=j*MAX_IN+i, then i++. After the last i -> DRAIN.
  - DRAIN (1 cycle): issue b_addr=j; i=0.
  - BIAS (1 cycle): neu_en=1, neu_mac=1.
  - WB (1 cycle): out_we=1, out_addr=j, out_data=neu_out. If j==n_neu-1 -> DONE, otherwise j++ -> ACC.
  - DONE (1 cycle): done=1 -> IDLE.
- neu_en / neu_mac are registered:
  - neu_en=1, mac=0 for exactly n_in cycles per neuron, i.e. the cycles after each ACC cycle, aligned with the returning memory data.
  - mac=1 only in BIAS.
- Latency per neuron: n_in+3 cycles. Per layer: n_neu*(n_in+3)+2 cycles from the cycle start is sampled to the done pulse.
- Accumulator clearing: no clear between neurons; the mac edge clears the accumulator.
- abort in any non-IDLE state:
  - Next state is IDLE, with a neu_clr pulse that cycle.
  - neu_en, neu_mac and out_we are forced to 0 that cycle.
  - No done pulse; writes already issued remain.
- abort together with start in IDLE: stay IDLE.
- Async rst mid-layer: immediate return to reset values; no done pulse.
- Counter wrap: i and j never exceed the latched count minus 1. w_addr is always below MAX_IN*MAX_NEU.

Decomposition:
- Shared package/include (nn_pkg), which holds:
  - DATA_W=16 and FRAC_W=8 (Q8.8)
  - state encoding IDLE, CLR, ACC, DRAIN, BIAS, WB, DONE
- Sub-module: nlc_addr_gen, holding the i/j counters, the stride multiply j*MAX_IN and the terminal-count flags. The FSM stays in neuron_layer_ctrl.

Test Plan:
- Basic layer, real neuron, cfg_n_in=2, cfg_n_neu=1:
  - Stimulus: inputs 0x0280, 0x0380; weights 0x0080, 0x0100; bias 0x0080.
  - Response: neu_en high 2 cycles then mac 1 cycle; out_we with out_data=0x0540; done at cycle 7.
- Multi-neuron, n_in=3, n_neu=4, weights row j = j+1.0:
  - Response: 4 writes at out_addr 0..3, spaced 6 cycles apart; w_addr sequence 0,1,2,8,9,10,16,...; done at cycle 26.
- Zero/clamp config:
  - cfg_n_neu=0 -> CLR then done after 2 cycles, no out_we.
  - cfg_n_in=15 with MAX_IN=8 -> exactly 8 neu_en cycles per neuron.
- Abort mid-ACC of neuron 1:
  - Response: IDLE next cycle, neu_clr=1, no done, only out_addr 0 was written.
  - A fresh start afterwards completes normally.
- start while busy, and start+abort in IDLE:
  - Both ignored; busy/done timing is unchanged.
- Async rst asserted mid-BIAS, between clock edges:
  - All outputs 0 immediately; no out_we at the next edge.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and layer-sequencer state encoding for the neural-network datapath.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_BIAS  = 3'd4,
    S_WB    = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/nlc_addr_gen.sv
// Input (i) / neuron (j) counters for the layer sequencer, with the weight-row
// stride multiply and terminal-count flags against the latched layer shape.
module nlc_addr_gen #(
  parameter  int MAX_IN  = 8,
  parameter  int MAX_NEU = 8,
  localparam int IW      = $clog2(MAX_IN),
  localparam int JW      = $clog2(MAX_NEU),
  localparam int WAW     = $clog2(MAX_IN * MAX_NEU),
  localparam int CIW     = IW + 1,
  localparam int CJW     = JW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cnt_clr_i,
  input  logic           i_step_i,
  input  logic           j_step_i,
  input  logic [CIW-1:0] n_in_i,
  input  logic [CJW-1:0] n_neu_i,
  output logic [IW-1:0]  i_o,
  output logic [JW-1:0]  j_o,
  output logic [WAW-1:0] w_addr_o,
  output logic           i_last_o,
  output logic           j_last_o
);

  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;

  assign i_last_o = (CIW'(i_q) == n_in_i - CIW'(1));
  assign j_last_o = (CJW'(j_q) == n_neu_i - CJW'(1));

  // Stepping on the last index wraps to 0 so neither counter passes count-1.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (cnt_clr_i) begin
      i_d = '0;
      j_d = '0;
    end else begin
      if (i_step_i) i_d = i_last_o ? '0 : i_q + IW'(1);
      else          i_d = i_q;
      if (j_step_i) j_d = j_last_o ? '0 : j_q + JW'(1);
      else          j_d = j_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_o      = i_q;
  assign j_o      = j_q;
  assign w_addr_o = WAW'(j_q) * WAW'(MAX_IN) + WAW'(i_q);

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Runs one fully-connected layer through a single neuron MAC: streams input and
// weight rows, applies the bias, and writes each neuron result to the output buffer.
module neuron_layer_ctrl #(
  parameter  int MAX_IN  = 8,
  parameter  int MAX_NEU = 8,
  parameter  int DATA_W  = 16,
  localparam int IW      = $clog2(MAX_IN),
  localparam int JW      = $clog2(MAX_NEU),
  localparam int WAW     = $clog2(MAX_IN * MAX_NEU),
  localparam int CIW     = IW + 1,
  localparam int CJW     = JW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CIW-1:0]    cfg_n_in,
  input  logic [CJW-1:0]    cfg_n_neu,
  output logic              busy,
  output logic              done,
  output logic [IW-1:0]     in_addr,
  input  logic [DATA_W-1:0] in_rdata,
  output logic [WAW-1:0]    w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [JW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              neu_clr,
  output logic              neu_en,
  output logic              neu_mac,
  output logic [DATA_W-1:0] neu_n_in,
  output logic [DATA_W-1:0] neu_wgh,
  output logic [DATA_W-1:0] neu_bias,
  input  logic [DATA_W-1:0] neu_out,
  output logic              out_we,
  output logic [JW-1:0]     out_addr,
  output logic [DATA_W-1:0] out_data
);

  import nn_pkg::*;

  state_e         state_q;
  logic [CIW-1:0] n_in_q, n_in_d;
  logic [CJW-1:0] n_neu_q, n_neu_d;
  logic           busy_q, done_q, clr_q, en_q, mac_q, we_q;
  logic           kill, cnt_clr, i_step, j_step, i_last, j_last;
  logic [IW-1:0]  i_idx;
  logic [JW-1:0]  j_idx;

  assign n_in_d  = (cfg_n_in  > CIW'(MAX_IN))  ? CIW'(MAX_IN)  : cfg_n_in;
  assign n_neu_d = (cfg_n_neu > CJW'(MAX_NEU)) ? CJW'(MAX_NEU) : cfg_n_neu;

  assign kill    = abort && (state_q != S_IDLE);
  assign cnt_clr = kill || (state_q == S_CLR) || (state_q == S_DONE);
  assign i_step  = (state_q == S_ACC);
  assign j_step  = (state_q == S_WB) && !j_last;

  nlc_addr_gen #(
    .MAX_IN  (MAX_IN),
    .MAX_NEU (MAX_NEU)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .cnt_clr_i (cnt_clr),
    .i_step_i  (i_step),
    .j_step_i  (j_step),
    .n_in_i    (n_in_q),
    .n_neu_i   (n_neu_q),
    .i_o       (i_idx),
    .j_o       (j_idx),
    .w_addr_o  (w_addr),
    .i_last_o  (i_last),
    .j_last_o  (j_last)
  );

  // Enables are registered one cycle behind ACC/DRAIN so they line up with
  // the memory data returning for the address issued in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_in_q  <= '0;
      n_neu_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      mac_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      en_q   <= 1'b0;
      mac_q  <= 1'b0;
      we_q   <= 1'b0;
      if (kill) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        clr_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              n_in_q  <= n_in_d;
              n_neu_q <= n_neu_d;
              busy_q  <= 1'b1;
              clr_q   <= 1'b1;
              state_q <= S_CLR;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_CLR: begin
            if ((n_in_q == '0) || (n_neu_q == '0)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_ACC;
            end
          end
          S_ACC: begin
            en_q    <= 1'b1;
            state_q <= i_last ? S_DRAIN : S_ACC;
          end
          S_DRAIN: begin
            en_q    <= 1'b1;
            mac_q   <= 1'b1;
            state_q <= S_BIAS;
          end
          S_BIAS: begin
            we_q    <= 1'b1;
            state_q <= S_WB;
          end
          S_WB: begin
            if (j_last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_ACC;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign neu_clr  = clr_q;
  assign neu_en   = en_q;
  assign neu_mac  = mac_q;
  assign out_we   = we_q;
  assign in_addr  = i_idx;
  assign b_addr   = j_idx;
  assign out_addr = j_idx;
  assign neu_n_in = in_rdata;
  assign neu_wgh  = w_rdata;
  assign neu_bias = b_rdata;
  assign out_data = we_q ? neu_out : '0;

endmodule
